isa_tx_framer: RTL and testbench
================================

ISA_TX_FRAMER -- requirements
Module: isa_tx_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: word FIFO depth in 64-bit entries; power of two, minimum 2.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-003 SHALL have port I_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port I_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port I_tx_data, input, 64: decoded word {addr[31:0], data[31:0]}.
REQ-006 SHALL have port I_tx_en, input, 1: one-cycle write strobe for I_tx_data.
REQ-007 SHALL have port O_tx_ready, output, 1: FIFO can accept a word this cycle.
REQ-008 SHALL have port O_byte, output, 8: serial byte to the link.
REQ-009 SHALL have port O_byte_valid, output, 1: O_byte is valid.
REQ-010 SHALL have port I_byte_ready, input, 1: link accepts O_byte.
REQ-011 SHALL have port O_frame_start, output, 1: high while the header byte is presented.
REQ-012 SHALL have port I_ovf_clr, input, 1: clears O_overflow.
REQ-013 SHALL have port O_overflow, output, 1: sticky flag, a word was dropped.
REQ-014 SHALL have port O_level, output, $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-015 SHALL push I_tx_data when I_tx_en=1 and O_tx_ready=1; O_tx_ready SHALL equal (O_level != DEPTH), based on registered occupancy.
REQ-016 SHALL drop the word and set O_overflow on the next edge when I_tx_en=1 and O_tx_ready=0; O_overflow holds until I_ovf_clr=1 or reset; a set event in the same cycle as I_ovf_clr SHALL win.
REQ-017 SHALL use a framer FSM with states IDLE, HDR, DATA, CSUM.
REQ-018 In IDLE with O_level>0, SHALL pop one word into a 64-bit shift register, clear the checksum, and go to HDR on the next edge.
REQ-019 HDR SHALL drive O_byte=SYNC_BYTE, O_byte_valid=1, O_frame_start=1; on I_byte_ready go to DATA.
REQ-020 DATA SHALL send 8 bytes MSB first (addr[31:24] first, data[7:0] last) using a 3-bit counter; each byte advances only on O_byte_valid&I_byte_ready; checksum SHALL accumulate as the XOR of each accepted data byte; after byte 7 is accepted, go to CSUM.
REQ-021 CSUM SHALL drive O_byte = the XOR of the 8 data bytes; on I_byte_ready go to IDLE.
REQ-022 The frame SHALL be 10 bytes; O_byte and O_byte_valid SHALL remain stable while I_byte_ready=0.
REQ-023 Latency: a word pushed at edge N with an empty FIFO and FSM in IDLE SHALL be popped at edge N+1, and the header SHALL be valid after edge N+2.
REQ-024 A push and a pop at the same edge SHALL leave O_level unchanged; a push at full is rejected even if a pop occurs at the same edge.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; O_level SHALL never exceed DEPTH or underflow.
REQ-026 A new frame SHALL start only from IDLE; back-to-back frames SHALL have exactly one IDLE cycle between the checksum acceptance and the next header.

Reset
REQ-027 On I_rst=1, asynchronously: FSM=IDLE, O_level=0, pointers=0, O_byte=8'h00, O_byte_valid=0, O_frame_start=0, O_overflow=0, checksum=0, counter=0; O_tx_ready=1 after reset.
REQ-028 Reset mid-frame SHALL abandon the frame and discard the FIFO contents; no partial frame resumes.

Structure
REQ-029 Package isa_link_pkg SHALL hold: the FSM state enum, the SYNC_BYTE default, FRAME_BYTES=10 and WORD_W=64.
REQ-030 The FIFO SHALL be a sub-module isa_word_fifo (single-clock, registered occupancy, push/pop/full/empty/level); the FSM, shift register and checksum SHALL be in isa_tx_framer.

Verification
REQ-031 Push 64'h4000_1000_0000_0005 with I_byte_ready=1 -> bytes A5,40,00,10,00,00,00,00,05,55 on consecutive cycles, O_frame_start high only on A5.
REQ-032 Same word with I_byte_ready toggling 1,0 -> the same 10 bytes, each held stable while ready=0.
REQ-033 Hold I_byte_ready=0 and push 5 words -> words 1-4 accepted, O_level=4, O_tx_ready=0, 5th word dropped, O_overflow=1; pulse I_ovf_clr -> O_overflow=0.
REQ-034 With O_level=4 and I_byte_ready=1, push on the pop edge -> push rejected, O_level=3; a push on the next cycle is accepted.
REQ-035 Assert I_rst during DATA byte 3 -> O_byte_valid=0 immediately, O_level=0; a later push yields a full frame starting with A5.
REQ-036 Push 6 words across wrap at DEPTH=4 with I_byte_ready=1 -> 6 frames in push order with correct checksums.

Source files
------------

// File: rtl/isa_link_pkg.sv
// Shared definitions for the ISA link transmit path: framer states and frame constants.
package isa_link_pkg;

    localparam int unsigned WORD_W            = 64;
    localparam int unsigned FRAME_BYTES       = 10;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} tx_state_e;

endpackage

// File: rtl/isa_word_fifo.sv
// Single-clock word FIFO with registered occupancy; full/empty derive from the level register.
module isa_word_fifo
    import isa_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     pop,
    output logic [WORD_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [WORD_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push at full is refused even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/isa_tx_framer.sv
// Serialises buffered {addr,data} words into 10-byte frames: sync, 8 data bytes MSB first, XOR.
module isa_tx_framer
    import isa_link_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic [WORD_W-1:0]        I_tx_data,
    input  logic                     I_tx_en,
    output logic                     O_tx_ready,
    output logic [7:0]               O_byte,
    output logic                     O_byte_valid,
    input  logic                     I_byte_ready,
    output logic                     O_frame_start,
    input  logic                     I_ovf_clr,
    output logic                     O_overflow,
    output logic [$clog2(DEPTH):0]   O_level
);

    localparam logic [2:0] LAST_DATA = 3'(FRAME_BYTES - 3);

    tx_state_e         state;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] fifo_rdata;
    logic [7:0]        csum;
    logic [2:0]        cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    isa_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (I_clk),
        .rst   (I_rst),
        .push  (I_tx_en),
        .wdata (I_tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (O_level)
    );

    assign O_tx_ready = !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;

    // Setting beats clearing so a drop in the clear cycle is never lost.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_overflow <= 1'b0;
        end else if (I_tx_en && !O_tx_ready) begin
            O_overflow <= 1'b1;
        end else if (I_ovf_clr) begin
            O_overflow <= 1'b0;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state         <= IDLE;
            shift         <= '0;
            csum          <= '0;
            cnt           <= '0;
            O_byte        <= '0;
            O_byte_valid  <= 1'b0;
            O_frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= fifo_rdata;
                        csum  <= '0;
                        state <= HDR;
                    end
                end
                HDR: begin
                    // First HDR cycle loads the registered header outputs.
                    if (!O_byte_valid) begin
                        O_byte        <= SYNC_BYTE;
                        O_byte_valid  <= 1'b1;
                        O_frame_start <= 1'b1;
                    end else if (I_byte_ready) begin
                        O_byte        <= shift[WORD_W-1 -: 8];
                        shift         <= {shift[WORD_W-9:0], 8'h00};
                        O_frame_start <= 1'b0;
                        cnt           <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (I_byte_ready) begin
                        csum <= csum ^ O_byte;
                        if (cnt == LAST_DATA) begin
                            O_byte <= csum ^ O_byte;
                            state  <= CSUM;
                        end else begin
                            O_byte <= shift[WORD_W-1 -: 8];
                            shift  <= {shift[WORD_W-9:0], 8'h00};
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (I_byte_ready) begin
                        O_byte       <= '0;
                        O_byte_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isa_tx_framer.sv
// Directed bench for isa_tx_framer: hand-computed frames, backpressure, overflow, reset, wrap.
module tb_isa_tx_framer;
    import isa_link_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] W_A = 64'h4000_1000_0000_0005;
    localparam logic [63:0] W_B = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tx_data;
    logic        tx_en;
    logic        tx_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_start;
    logic        ovf_clr;
    logic        overflow;
    logic [2:0]  level;

    int vecs = 0;
    int errs = 0;

    logic [7:0]  exp_a [10] = '{8'hA5, 8'h40, 8'h00, 8'h10, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h05, 8'h55};
    logic [63:0] burst [5]  = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                                64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004,
                                64'h5555_0000_0000_0005};
    logic [63:0] wrap  [6]  = '{64'hDEAD_BEEF_0000_0001, 64'h8000_0004_1234_5678,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                64'hA5A5_5A5A_0F0F_F0F0, 64'h0102_0304_0506_0708};
    logic [7:0]  got_b [$];
    logic        got_fs [$];

    always #5 clk = ~clk;

    isa_tx_framer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_tx_data     (tx_data),
        .I_tx_en       (tx_en),
        .O_tx_ready    (tx_ready),
        .O_byte        (byte_out),
        .O_byte_valid  (byte_valid),
        .I_byte_ready  (byte_ready),
        .O_frame_start (frame_start),
        .I_ovf_clr     (ovf_clr),
        .O_overflow    (overflow),
        .O_level       (level)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] frame_byte(input logic [63:0] w, input int idx);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 8; k++) x = x ^ w[63-8*k -: 8];
        if (idx == 0) return 8'hA5;
        if (idx == 9) return x;
        return w[63-8*(idx-1) -: 8];
    endfunction

    initial begin
        rst        = 1'b1;
        tx_en      = 1'b0;
        tx_data    = '0;
        byte_ready = 1'b0;
        ovf_clr    = 1'b0;
        #1;
        chk("rst_valid",    64'(byte_valid),  64'd0);
        chk("rst_byte",     64'(byte_out),    64'd0);
        chk("rst_fs",       64'(frame_start), 64'd0);
        chk("rst_level",    64'(level),       64'd0);
        chk("rst_tx_ready", 64'(tx_ready),    64'd1);
        chk("rst_ovf",      64'(overflow),    64'd0);
        step();
        step();
        rst = 1'b0;

        // Single frame, link always ready
        byte_ready = 1'b1;
        tx_data    = W_A;
        tx_en      = 1'b1;
        step();
        tx_en = 1'b0;
        chk("lat_level_push", 64'(level),      64'd1);
        chk("lat_valid_push", 64'(byte_valid), 64'd0);
        step();
        chk("lat_level_pop",  64'(level),      64'd0);
        chk("lat_valid_pop",  64'(byte_valid), 64'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("frame_byte",  64'(byte_out),    64'(exp_a[i]));
            chk("frame_valid", 64'(byte_valid),  64'd1);
            chk("frame_start", 64'(frame_start), 64'(i == 0));
            step();
        end
        chk("frame_end_valid", 64'(byte_valid), 64'd0);

        // Same frame with ready toggling; byte must hold while ready is low
        byte_ready = 1'b0;
        tx_data    = W_A;
        tx_en      = 1'b1;
        step();
        tx_en = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_byte",       64'(byte_out),   64'(exp_a[i]));
            chk("bp_valid",      64'(byte_valid), 64'd1);
            step();
            chk("bp_hold_byte",  64'(byte_out),   64'(exp_a[i]));
            chk("bp_hold_valid", 64'(byte_valid), 64'd1);
            byte_ready = 1'b1;
            step();
            byte_ready = 1'b0;
        end
        chk("bp_end_valid", 64'(byte_valid), 64'd0);

        // Park the framer on W_B's header, then overfill the FIFO
        tx_data = W_B;
        tx_en   = 1'b1;
        step();
        tx_en = 1'b0;
        step();
        chk("ovf_pre_level", 64'(level), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tx_data = burst[k];
            tx_en   = 1'b1;
            step();
            if (k == 3) begin
                chk("full_level",    64'(level),    64'd4);
                chk("full_tx_ready", 64'(tx_ready), 64'd0);
                chk("full_ovf_clr",  64'(overflow), 64'd0);
            end
        end
        tx_en = 1'b0;
        chk("ovf_set",       64'(overflow), 64'd1);
        chk("ovf_level",     64'(level),    64'd4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared",   64'(overflow), 64'd0);
        ovf_clr = 1'b1;
        tx_en   = 1'b1;
        step();
        ovf_clr = 1'b0;
        tx_en   = 1'b0;
        chk("ovf_set_wins",  64'(overflow), 64'd1);
        chk("ovf_wins_lvl",  64'(level),    64'd4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared2",  64'(overflow), 64'd0);

        // Drain W_B, then push on the pop edge while full
        byte_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("drain_byte", 64'(byte_out), 64'(frame_byte(W_B, i)));
            step();
        end
        chk("drain_idle_valid", 64'(byte_valid), 64'd0);
        chk("drain_idle_level", 64'(level),      64'd4);
        tx_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tx_en   = 1'b1;
        step();
        chk("popedge_level",    64'(level),    64'd3);
        chk("popedge_ovf",      64'(overflow), 64'd1);
        chk("popedge_tx_ready", 64'(tx_ready), 64'd1);
        tx_data = 64'h600D_600D_600D_600D;
        step();
        tx_en = 1'b0;
        chk("next_push_level", 64'(level), 64'd4);

        // Clean slate, then reset in the middle of data byte 3
        rst = 1'b1;
        step();
        rst        = 1'b0;
        byte_ready = 1'b1;
        tx_data    = W_A;
        tx_en      = 1'b1;
        step();
        tx_data = W_B;
        step();
        tx_en = 1'b0;
        step();
        chk("mid_hdr", 64'(byte_out), 64'hA5);
        step();
        step();
        step();
        chk("mid_data2", 64'(byte_out), 64'h10);
        chk("mid_level", 64'(level),    64'd1);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    64'(byte_valid),  64'd0);
        chk("mid_rst_level",    64'(level),       64'd0);
        chk("mid_rst_byte",     64'(byte_out),    64'd0);
        chk("mid_rst_fs",       64'(frame_start), 64'd0);
        chk("mid_rst_tx_ready", 64'(tx_ready),    64'd1);
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("no_resume_valid", 64'(byte_valid), 64'd0);
        chk("no_resume_level", 64'(level),      64'd0);
        tx_data = W_A;
        tx_en   = 1'b1;
        step();
        tx_en = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_byte", 64'(byte_out), 64'(exp_a[i]));
            step();
        end

        // Six frames across the pointer wrap
        begin
            int nxt = 0;
            for (int c = 0; c < 200 && got_b.size() < 60; c++) begin
                if (byte_valid) begin
                    got_b.push_back(byte_out);
                    got_fs.push_back(frame_start);
                end
                if (nxt < 6 && tx_ready) begin
                    tx_data = wrap[nxt];
                    tx_en   = 1'b1;
                    nxt++;
                end else begin
                    tx_en = 1'b0;
                end
                step();
            end
            tx_en = 1'b0;
        end
        chk("wrap_count", 64'(got_b.size()), 64'd60);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 10; i++) begin
                if (f * 10 + i < got_b.size()) begin
                    chk("wrap_byte", 64'(got_b[f*10+i]),  64'(frame_byte(wrap[f], i)));
                    chk("wrap_fs",   64'(got_fs[f*10+i]), 64'(i == 0));
                end
            end
        end
        chk("wrap_ovf", 64'(overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
